// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and defaults: FSM encoding, output-register layout, reset PC, NOP.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        valid;
  } fetch_out_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_1000;
  localparam logic [31:0] NOP_IR_DEF   = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {ir, pc} hold buffer; 1-cycle load, flush wins over load, load wins over drain.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        flush,
  input  logic [31:0] ld_ir,
  input  logic [31:0] ld_pc,
  output logic [31:0] buf_ir,
  output logic [31:0] buf_pc,
  output logic        full
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_ir <= NOP_IR_DEF;
      buf_pc <= '0;
      full   <= 1'b0;
    end else if (flush) begin
      full   <= 1'b0;
    end else if (load) begin
      buf_ir <= ld_ir;
      buf_pc <= ld_pc;
      full   <= 1'b1;
    end else if (drain) begin
      full   <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC + request FSM + registered {ir, pc_out, valid_out}; mem_ready in N -> valid_out in N+1.
// Stall parks one returned word in the hold buffer (FULL, no request); FETCH_PERF_EN adds fetch/bubble counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_IR   = NOP_IR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc_out,
  output logic        valid_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  redirect_pc, redirect_pc_nxt;
  fetch_out_t   out_q, out_nxt;
  logic [31:0]  target;
  logic         buf_load, buf_drain, buf_flush;
  logic [31:0]  buf_ir, buf_pc;
  logic         buf_full;
  logic         load_valid, load_bubble;

  assign target = word_align(branch_target);

  // Request depends only on registered state (plus reset), never on mem_ready.
  assign mem_req  = !reset && (state != FULL);
  assign mem_addr = pc;

  assign ir        = out_q.ir;
  assign pc_out    = out_q.pc;
  assign valid_out = out_q.valid;

  fetch_hold_buf u_hold_buf (
    .clk    (clk),
    .reset  (reset),
    .load   (buf_load),
    .drain  (buf_drain),
    .flush  (buf_flush),
    .ld_ir  (mem_rdata),
    .ld_pc  (pc),
    .buf_ir (buf_ir),
    .buf_pc (buf_pc),
    .full   (buf_full)
  );

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    redirect_pc_nxt = redirect_pc;
    out_nxt         = out_q;
    buf_load        = 1'b0;
    buf_drain       = 1'b0;
    buf_flush       = 1'b0;
    load_valid      = 1'b0;
    load_bubble     = 1'b0;

    if (branch_taken) begin
      buf_flush     = 1'b1;
      out_nxt.ir    = NOP_IR;
      out_nxt.valid = 1'b0;
      load_bubble   = 1'b1;
      case (state)
        FETCH: begin
          if (mem_ready) begin
            pc_nxt = target;
          end else begin
            redirect_pc_nxt = target;
            state_nxt       = SQUASH;
          end
        end
        FULL: begin
          pc_nxt    = target;
          state_nxt = FETCH;
        end
        SQUASH: begin
          redirect_pc_nxt = target;
          if (mem_ready) begin
            pc_nxt    = target;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            pc_nxt = pc + PC_INC;
            if (stall) begin
              buf_load  = 1'b1;
              state_nxt = FULL;
            end else begin
              out_nxt    = '{ir: mem_rdata, pc: pc, valid: 1'b1};
              load_valid = 1'b1;
            end
          end else if (!stall) begin
            out_nxt.ir    = NOP_IR;
            out_nxt.valid = 1'b0;
            load_bubble   = 1'b1;
          end
        end
        FULL: begin
          if (!stall) begin
            out_nxt    = '{ir: buf_ir, pc: buf_pc, valid: buf_full};
            load_valid = buf_full;
            buf_drain  = 1'b1;
            state_nxt  = FETCH;
          end
        end
        SQUASH: begin
          // The abandoned request must still complete before the target is issued.
          if (mem_ready) begin
            pc_nxt    = redirect_pc;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redirect_pc <= RESET_PC;
      out_q       <= '{ir: NOP_IR, pc: 32'h0, valid: 1'b0};
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      redirect_pc <= redirect_pc_nxt;
      out_q       <= out_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (load_valid)  fetch_count  <= fetch_count + 32'd1;
      if (load_bubble) bubble_count <= bubble_count + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = load_valid ^ load_bubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addr ^ 32'hA5A5_0000, ready driven per cycle.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, mem_ready;
  logic [31:0] branch_target, mem_addr, mem_rdata, ir, pc_out;
  logic        mem_req, valid_out;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, bubble_count;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

  fetch_stage #(.RESET_PC(32'h0000_1000), .NOP_IR(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .ir            (ir),
    .pc_out        (pc_out),
    .valid_out     (valid_out)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count   (fetch_count),
    .bubble_count  (bubble_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; mem_ready = 1'b1;
    step(); step();
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", valid_out); end
    tests++; if (ir !== 32'h0) begin fails++; $display("FAIL reset_ir got=%h exp=00000000", ir); end
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL reset_pc_out got=%h exp=00000000", pc_out); end
    reset = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000) begin fails++; $display("FAIL first_req got=%0b/%h exp=1/00001000", mem_req, mem_addr); end
  endtask

  task automatic test_stream();
    step();
    tests++; if (pc_out !== 32'h1000 || ir !== 32'hA5A5_1000 || valid_out !== 1'b1) begin fails++; $display("FAIL stream0 got=%h/%h/%0b exp=00001000/a5a51000/1", pc_out, ir, valid_out); end
    step();
    tests++; if (pc_out !== 32'h1004 || ir !== 32'hA5A5_1004 || valid_out !== 1'b1) begin fails++; $display("FAIL stream1 got=%h/%h/%0b exp=00001004/a5a51004/1", pc_out, ir, valid_out); end
    tests++; if (mem_addr !== 32'h1008) begin fails++; $display("FAIL stream_addr got=%h exp=00001008", mem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    step();
    tests++; if (mem_req !== 1'b0 || pc_out !== 32'h1004 || valid_out !== 1'b1) begin fails++; $display("FAIL stall_full got=%0b/%h/%0b exp=0/00001004/1", mem_req, pc_out, valid_out); end
    step(); step();
    tests++; if (mem_req !== 1'b0 || pc_out !== 32'h1004) begin fails++; $display("FAIL stall_hold got=%0b/%h exp=0/00001004", mem_req, pc_out); end
    stall = 1'b0;
    step();
    tests++; if (pc_out !== 32'h1008 || ir !== 32'hA5A5_1008 || valid_out !== 1'b1) begin fails++; $display("FAIL stall_release got=%h/%h/%0b exp=00001008/a5a51008/1", pc_out, ir, valid_out); end
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100C) begin fails++; $display("FAIL stall_resume_req got=%0b/%h exp=1/0000100c", mem_req, mem_addr); end
    step();
    tests++; if (pc_out !== 32'h100C || valid_out !== 1'b1) begin fails++; $display("FAIL stall_next got=%h/%0b exp=0000100c/1", pc_out, valid_out); end
  endtask

  task automatic test_miss();
    mem_ready = 1'b0;
    step();
    tests++; if (valid_out !== 1'b0 || ir !== 32'h0 || pc_out !== 32'h100C) begin fails++; $display("FAIL miss_bubble got=%0b/%h/%h exp=0/00000000/0000100c", valid_out, ir, pc_out); end
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h1010) begin fails++; $display("FAIL miss_req got=%0b/%h exp=1/00001010", mem_req, mem_addr); end
  endtask

  task automatic test_squash();
    branch_taken = 1'b1; branch_target = 32'h2000; mem_ready = 1'b0;
    step();
    tests++; if (valid_out !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h1010) begin fails++; $display("FAIL squash_hold got=%0b/%0b/%h exp=0/1/00001010", valid_out, mem_req, mem_addr); end
    branch_taken = 1'b0;
    step();
    tests++; if (mem_addr !== 32'h1010 || valid_out !== 1'b0) begin fails++; $display("FAIL squash_wait got=%h/%0b exp=00001010/0", mem_addr, valid_out); end
    mem_ready = 1'b1;
    step();
    tests++; if (mem_addr !== 32'h2000 || valid_out !== 1'b0) begin fails++; $display("FAIL squash_discard got=%h/%0b exp=00002000/0", mem_addr, valid_out); end
    step();
    tests++; if (pc_out !== 32'h2000 || ir !== 32'hA5A5_2000 || valid_out !== 1'b1) begin fails++; $display("FAIL squash_target got=%h/%h/%0b exp=00002000/a5a52000/1", pc_out, ir, valid_out); end
  endtask

  task automatic test_full_redirect();
    stall = 1'b1;
    step();
    tests++; if (mem_req !== 1'b0 || pc_out !== 32'h2000) begin fails++; $display("FAIL fullr_enter got=%0b/%h exp=0/00002000", mem_req, pc_out); end
    branch_taken = 1'b1; branch_target = 32'h3000;
    step();
    tests++; if (valid_out !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h3000) begin fails++; $display("FAIL fullr_flush got=%0b/%0b/%h exp=0/1/00003000", valid_out, mem_req, mem_addr); end
    branch_taken = 1'b0; stall = 1'b0;
    step();
    tests++; if (pc_out !== 32'h3000 || ir !== 32'hA5A5_3000 || valid_out !== 1'b1) begin fails++; $display("FAIL fullr_first got=%h/%h/%0b exp=00003000/a5a53000/1", pc_out, ir, valid_out); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    step();
    tests++; if (mem_addr !== 32'hFFFF_FFFC || valid_out !== 1'b0) begin fails++; $display("FAIL wrap_align got=%h/%0b exp=fffffffc/0", mem_addr, valid_out); end
    branch_taken = 1'b0;
    step();
    tests++; if (pc_out !== 32'hFFFF_FFFC || mem_addr !== 32'h0) begin fails++; $display("FAIL wrap_inc got=%h/%h exp=fffffffc/00000000", pc_out, mem_addr); end
    step();
    tests++; if (pc_out !== 32'h0 || ir !== 32'hA5A5_0000 || valid_out !== 1'b1) begin fails++; $display("FAIL wrap_zero got=%h/%h/%0b exp=00000000/a5a50000/1", pc_out, ir, valid_out); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    step();
    reset = 1'b0; mem_ready = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    repeat (5) step();
    mem_ready = 1'b0;
    repeat (2) step();
    mem_ready = 1'b1;
    repeat (5) step();
    tests++; if (fetch_count !== 32'd10) begin fails++; $display("FAIL perf_fetch got=%0d exp=10", fetch_count); end
    tests++; if (bubble_count !== 32'd2) begin fails++; $display("FAIL perf_bubble got=%0d exp=2", bubble_count); end
    #2 reset = 1'b1;
    #1;
    tests++; if (fetch_count !== 32'd0 || bubble_count !== 32'd0) begin fails++; $display("FAIL perf_async_reset got=%0d/%0d exp=0/0", fetch_count, bubble_count); end
    step();
    reset = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; mem_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_miss();
    test_squash();
    test_full_redirect();
    test_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline, sitting directly upstream of the decode stage. Holds the program counter, issues word fetches to the instruction cache/memory over a request/ready handshake, and presents `{ir, pc_out, valid_out}` to decode through a registered pipeline boundary. Honours pipeline stalls through a one-entry hold buffer, and accepts branch redirects from execute, squashing any in-flight fetch.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_1000: first fetch address after reset.
- `NOP_IR`, 32'h0000_0000: encoding driven on `ir` for bubbles.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: decode cannot accept; hold the output register.
- `branch_taken` in 1: redirect request from execute.
- `branch_target` in 32: redirect address; bits [1:0] are ignored and forced to 00.
- `mem_req` out 1: fetch request.
- `mem_addr` out 32: word address of the request; stable while `mem_req`=1.
- `mem_ready` in 1: request completes this cycle; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: fetched instruction.
- `ir` out 32: instruction to decode.
- `pc_out` out 32: address of `ir`.
- `valid_out` out 1: `ir` is a real instruction.
- `fetch_count` out 32: present only with `FETCH_PERF_EN`.
- `bubble_count` out 32: present only with `FETCH_PERF_EN`.

## Operation
Registers:
- `pc`: next fetch address.
- `redirect_pc`: pending redirect target.
- `buf_ir`, `buf_pc`: hold buffer contents.
- `state`: one of FETCH, FULL, SQUASH.

FETCH
- `mem_req`=1, `mem_addr`=`pc`.
- `mem_ready`=1 with `stall`=0: load output with {`mem_rdata`, `pc`, 1}; `pc`+=4; stay in FETCH.
- `mem_ready`=1 with `stall`=1: load buffer; `pc`+=4; go to FULL; output register unchanged.
- `mem_ready`=0 with `stall`=0: output becomes a bubble ({`NOP_IR`, `pc_out` unchanged, 0}).
- `mem_ready`=0 with `stall`=1: nothing changes.

FULL
- `mem_req`=0.
- `stall`=0: output loads {`buf_ir`, `buf_pc`, 1}; go to FETCH.

SQUASH
- `mem_req`=1, `mem_addr`=`pc` (the old, abandoned address).
- `mem_ready`=1: discard `mem_rdata`; `pc`←`redirect_pc`; go to FETCH.

Redirect (`branch_taken`=1) has priority over `stall` and over any data return:
- The output register is flushed to a bubble next cycle.
- The buffer is discarded.
- In FETCH with `mem_ready`=0: `redirect_pc`←target; go to SQUASH.
- In FETCH with `mem_ready`=1: the returned data is dropped; `pc`←target; stay in FETCH.
- In FULL: `pc`←target; go to FETCH.
- In SQUASH: `redirect_pc`←target (latest redirect wins); if `mem_ready`=1 in the same cycle, `pc`←new target and go to FETCH.

Arithmetic: `pc` increments modulo 2^32, so 32'hFFFF_FFFC wraps to 0. `RESET_PC[1:0]` must be 00.

## Timing
- Reset values: `pc`=`RESET_PC`, `state`=FETCH, `ir`=`NOP_IR`, `pc_out`=0, `valid_out`=0, buffer empty, counters 0.
- `mem_req` is forced to 0 while `reset`=1 and asserts in the first cycle after deassertion.
- Reset mid-transaction abandons the request; the memory side must tolerate this.
- Latency: `mem_ready` in cycle N → `valid_out` in cycle N+1.
- Throughput: 1 instruction/cycle with zero-wait memory.
- Redirect asserted in cycle N:
  - `valid_out`=0 in N+1.
  - First target request in N+1 if no fetch was outstanding.
  - Otherwise, in the cycle after the squashed request completes.
- `mem_req`/`mem_addr` are driven combinationally from registered state only; no path from `mem_ready` to `mem_req`.

## Configuration
- `FETCH_PERF_EN` defined:
  - `fetch_count` increments on every output load with `valid_out`=1.
  - `bubble_count` increments on every output load with `valid_out`=0 caused by a miss or flush (not by stall).
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports and their counter logic are absent.

## Structure
- Shared package `fetch_pkg` holds:
  - the `fetch_state_t` encoding (FETCH, FULL, SQUASH);
  - `NOP_IR` and `RESET_PC` defaults;
  - the PC increment constant (4).
- One sub-module: `fetch_hold_buf`, the one-entry {ir, pc} register with load/drain/flush controls.
- The FSM, PC and output register live in the top level.

## Test plan
- Reset release, `RESET_PC`=0x1000, zero-wait memory returning `addr^0xA5A5_0000` → `pc_out` = 0x1000, 0x1004, 0x1008 on consecutive cycles, `valid_out`=1, starting the cycle after the first `mem_ready`.
- `stall` high for 3 cycles while the fetch of 0x1008 completes → FULL entered, `mem_req`=0, output holds 0x1004; on release, 0x1008 is presented, then 0x100C follows.
- Memory with 3-cycle latency, `branch_taken` with target 0x2000 in latency cycle 1 → old address held on `mem_addr` until ready, data discarded, next `mem_addr`=0x2000, no `valid_out` for the old instruction.
- Redirect to 0x3000 during FULL with `stall`=1 → `valid_out`=0 next cycle, buffered instruction never appears, first delivered `pc_out`=0x3000.
- `branch_target`=0xFFFF_FFFE followed by sequential fetch → `mem_addr` = 0xFFFF_FFFC, then 0x0000_0000.
- With `FETCH_PERF_EN`: 10 delivered instructions plus 2 miss bubbles → `fetch_count`=10, `bubble_count`=2; async reset mid-run zeroes both immediately.
